// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter that shares one buffered
// UART transmitter between N byte-stream requesters. A byte is written only when
// the transmitter FIFO fill is below 2^D - MARGIN, so the FIFO cannot overflow.
// Optional feature: define UART_ARB_TIMEOUT_EN to abandon a packet whose owner
// keeps REQ low mid-packet for T consecutive CHECK cycles.
module uart_tx_arbiter #(
    parameter int unsigned N      = 2,
    parameter int unsigned D      = 5,
    parameter int unsigned MARGIN = 2,
    parameter int unsigned T      = 255
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_last,
    input  logic [8*N-1:0] i_data,
    output logic [N-1:0]   o_ack,
    output logic [N-1:0]   o_grant,
    output logic           o_busy,
    output logic           o_err,
    output logic           o_tx_we,
    output logic           o_tx_a,
    output logic [31:0]    o_tx_wd,
    input  logic [31:0]    i_tx_rd
);

    localparam int unsigned PW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LIMIT = (1 << D) - MARGIN;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWrite
    } state_e;

    state_e        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_ack;
    logic          r_err;
    logic          r_tx_we;
    logic          r_tx_a;
    logic [31:0]   r_tx_wd;

    logic [PW-1:0] w_pick;
    logic          w_pick_valid;
    logic [PW-1:0] w_scan;
    logic [PW-1:0] w_next_ptr;
    logic          w_owner_req;
    logic          w_owner_last;
    logic [7:0]    w_owner_data;
    logic          w_room;
    logic          w_unused;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(T + 1);
    logic [CW-1:0] r_cnt;
`else
    logic          w_unused_timeout;
    assign w_unused_timeout = (T != 0);
`endif

    // Status bits other than overflow and fill are not needed here.
    assign w_unused = ^{i_tx_rd[31], i_tx_rd[29:8]};

    assign w_owner_req  = i_req[r_owner];
    assign w_owner_last = i_last[r_owner];
    assign w_owner_data = i_data[{r_owner, 3'b000} +: 8];
    assign w_next_ptr   = (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;
    // Fill is zero-extended to 9 bits so 2^D = 256 still compares correctly.
    assign w_room       = {1'b0, i_tx_rd[7:0]} < 9'(LIMIT);

    // Round-robin search: first set REQ bit at or above r_ptr, wrapping modulo N.
    always_comb begin
        w_pick       = r_ptr;
        w_pick_valid = 1'b0;
        w_scan       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_scan = PW'((32'(r_ptr) + k) % N);
            if (!w_pick_valid && i_req[w_scan]) begin
                w_pick       = w_scan;
                w_pick_valid = 1'b1;
            end
        end
    end

    // Arbiter FSM with registered transmitter-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_tx_we <= 1'b0;
            r_tx_a  <= 1'b1;
            r_tx_wd <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            // Outputs default to the status-read view; only the WRITE state overrides.
            r_ack   <= '0;
            r_tx_we <= 1'b0;
            r_tx_a  <= 1'b1;
            r_tx_wd <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick;
                        r_grant <= {{(N - 1){1'b0}}, 1'b1} << w_pick;
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    r_err <= r_err | i_tx_rd[30];
                    if (!w_owner_req) begin
`ifdef UART_ARB_TIMEOUT_EN
                        if (r_cnt == CW'(T - 1)) begin
                            r_grant <= '0;
                            r_ptr   <= w_next_ptr;
                            r_cnt   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`endif
                    end else begin
`ifdef UART_ARB_TIMEOUT_EN
                        r_cnt <= '0;
`endif
                        if (w_room) begin
                            r_ack   <= r_grant;
                            r_tx_we <= 1'b1;
                            r_tx_a  <= 1'b0;
                            r_tx_wd <= {24'd0, w_owner_data};
                            r_state <= StWrite;
                        end
                    end
                end
                StWrite: begin
`ifdef UART_ARB_TIMEOUT_EN
                    r_cnt <= '0;
`endif
                    if (w_owner_last) begin
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= StIdle;
                    end else begin
                        r_state <= StCheck;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ack   = r_ack;
    assign o_grant = r_grant;
    assign o_busy  = |r_grant;
    assign o_err   = r_err;
    assign o_tx_we = r_tx_we;
    assign o_tx_a  = r_tx_a;
    assign o_tx_wd = r_tx_wd;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected writes are queued from a
// packet-level round-robin model; a monitor pops one entry per TX_WE cycle.
module tb_uart_tx_arbiter;

    localparam int unsigned N      = 2;
    localparam int unsigned D      = 5;
    localparam int unsigned MARGIN = 2;
    localparam int unsigned T      = 8;
    localparam int unsigned LIMIT  = (1 << D) - MARGIN;

    typedef struct {
        int         r;
        logic [7:0] b;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [8*N-1:0] data;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           busy;
    logic           err;
    logic           tx_we;
    logic           tx_a;
    logic [31:0]    tx_wd;
    logic [31:0]    tx_rd;

    int   fill;
    logic ovf;
    bit   fifo_auto;
    bit   drain_en;
    int   checks;
    int   errors;

    exp_t       exp_q[$];
    logic [8:0] stim_q[N][$];  // bit 8 = last

    assign tx_rd = {fill != 0, ovf, 22'd0, fill[7:0]};

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N     (N),
        .D     (D),
        .MARGIN(MARGIN),
        .T     (T)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_req  (req),
        .i_last (last),
        .i_data (data),
        .o_ack  (ack),
        .o_grant(grant),
        .o_busy (busy),
        .o_err  (err),
        .o_tx_we(tx_we),
        .o_tx_a (tx_a),
        .o_tx_wd(tx_wd),
        .i_tx_rd(tx_rd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int r, input logic [7:0] b);
        exp_t x;
        x.r = r;
        x.b = b;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        last = '0;
        data = '0;
        tick();
        @(negedge clk);
        fill = 0;
        ovf  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_we"}, tx_we, 0);
        check({tag, "_a"}, tx_a, 1);
        check({tag, "_wd"}, tx_wd, 0);
    endtask

    // Returns at the negedge of the cycle in which ack[r] is high.
    task automatic wait_ack(input int r, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (ack[r] !== 1'b1) begin
            if (n == limit) begin
                fail_now("ack_wait");
                return;
            end
            n++;
            tick();
            @(negedge clk);
        end
    endtask

    task automatic gen_stim(input int max_pk, input int max_len);
        int npk;
        int len;
        for (int r = 0; r < N; r++) begin
            stim_q[r].delete();
            npk = $urandom_range(1, max_pk);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, max_len);
                for (int i = 0; i < len; i++) stim_q[r].push_back({i == len - 1, 8'($urandom)});
            end
        end
    endtask

    // Reference: whole packets granted round robin among requesters with work left.
    task automatic build_expected();
        logic [8:0] tmp[N][$];
        logic [8:0] e;
        int ptr;
        int pick;
        int r;
        ptr = 0;
        for (int i = 0; i < N; i++) tmp[i] = stim_q[i];
        do begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                r = (ptr + k) % N;
                if (pick < 0 && tmp[r].size() > 0) pick = r;
            end
            if (pick >= 0) begin
                do begin
                    e = tmp[pick].pop_front();
                    push_exp(pick, e[7:0]);
                end while (!e[8]);
                ptr = (pick + 1) % N;
            end
        end while (pick >= 0);
    endtask

    // Drives every requester from stim_q, obeying the hold-until-ACK contract.
    task automatic run_stream(input int max_cycles, input bit gaps);
        int         gap[N];
        bit         acked[N];
        bit         pending;
        int         cyc;
        logic [8:0] e;
        cyc = 0;
        for (int r = 0; r < N; r++) begin
            gap[r]   = 0;
            acked[r] = 1'b0;
        end
        forever begin
            pending = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (acked[r]) begin
                    e = stim_q[r].pop_front();
                    if (gaps && !e[8] && $urandom_range(0, 2) == 0) gap[r] = $urandom_range(1, 6);
                end
                if (gap[r] > 0) begin
                    req[r] = 1'b0;
                    gap[r]--;
                end else if (stim_q[r].size() > 0) begin
                    e              = stim_q[r][0];
                    req[r]         = 1'b1;
                    last[r]        = e[8];
                    data[8*r +: 8] = e[7:0];
                end else begin
                    req[r]  = 1'b0;
                    last[r] = 1'b0;
                end
                if (stim_q[r].size() > 0) pending = 1'b1;
            end
            if (!pending) break;
            if (cyc == max_cycles) begin
                fail_now("stream_budget");
                break;
            end
            @(negedge clk);
            for (int r = 0; r < N; r++) acked[r] = ack[r];
            tick();
            cyc++;
        end
    endtask

    // Downstream FIFO: fills on each write, optionally drains at random.
    initial begin
        logic we_s;
        forever begin
            @(negedge clk);
            we_s = tx_we;
            @(posedge clk);
            #1;
            if (fifo_auto) begin
                if (we_s) fill++;
                if (drain_en && fill > 0 && $urandom_range(0, 3) == 0) fill--;
            end
        end
    end

    // Monitor: every write is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy !== (|grant) || !$onehot0(grant)) begin
                check("grant_shape", {busy, grant}, {|grant, grant});
            end
            if (tx_we === 1'b1) begin
                check("write_addr", tx_a, 0);
                check("write_room", fill < LIMIT, 1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("write_owner", ack, 64'd1 << e.r);
                    check("write_data", tx_wd, {24'd0, e.b});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        fill      = 0;
        ovf       = 1'b0;
        fifo_auto = 1'b1;
        drain_en  = 1'b0;
        rst       = 1'b1;
        req       = '0;
        last      = '0;
        data      = '0;
        tick();
        tick();
        @(negedge clk);
        check_reset_vals("reset");
        tick();
        rst = 1'b0;

        // Single requester, single byte: latency 1 to grant, 2 to write.
        req  = 2'b01;
        data = {8'h00, 8'hA5};
        last = 2'b01;
        push_exp(0, 8'hA5);
        @(negedge clk);
        check("single_c0_grant", grant, 0);
        tick();
        @(negedge clk);
        check("single_c1_grant", grant, 2'b01);
        check("single_c1_we", tx_we, 0);
        check("single_c1_a", tx_a, 1);
        tick();
        @(negedge clk);
        check("single_c2_we", tx_we, 1);
        check("single_c2_ack", ack, 2'b01);
        tick();
        req = '0;
        @(negedge clk);
        check("single_c3_grant", grant, 0);
        check("single_c3_a", tx_a, 1);

        // Round robin: both requesters, three 2-byte packets each.
        tick();
        do_reset();
        for (int r = 0; r < N; r++) begin
            stim_q[r].delete();
            for (int i = 0; i < 6; i++) stim_q[r].push_back({i[0], 8'(16 * r + i + 1)});
        end
        build_expected();
        run_stream(200, 1'b0);

        // Backpressure: fill 30 blocks, fill 29 allows a write one cycle later.
        tick();
        do_reset();
        fifo_auto = 1'b0;
        fill      = 30;
        req       = 2'b01;
        data      = {8'h00, 8'h3C};
        last      = 2'b01;
        push_exp(0, 8'h3C);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_full_we", tx_we, 0);
            tick();
        end
        fill = 29;
        @(negedge clk);
        check("bp_drop_we", tx_we, 0);
        tick();
        @(negedge clk);
        check("bp_write_we", tx_we, 1);
        tick();
        req       = '0;
        fifo_auto = 1'b1;

        // Mid-packet stall: owner 0 idles 10 cycles, requester 1 must wait.
        tick();
        do_reset();
        req  = 2'b11;
        data = {8'h22, 8'h11};
        last = 2'b10;
        push_exp(0, 8'h11);
        push_exp(0, 8'h33);
        push_exp(1, 8'h22);
        wait_ack(0, 20);
        tick();
        req[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_grant", grant, 2'b01);
            tick();
        end
        req[0]    = 1'b1;
        data[7:0] = 8'h33;
        last[0]   = 1'b1;
        wait_ack(0, 20);
        tick();
        req[0] = 1'b0;
        wait_ack(1, 20);
        tick();
        req  = '0;
        last = '0;

        // Sticky ERR, then reset during WRITE.
        tick();
        do_reset();
        ovf  = 1'b1;
        req  = 2'b01;
        data = {8'h00, 8'h5A};
        last = 2'b00;
        push_exp(0, 8'h5A);
        wait_ack(0, 20);
        check("err_set", err, 1);
        tick();
        req = '0;
        ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err_sticky", err, 1);
            tick();
        end
        req  = 2'b01;
        data = {8'h00, 8'hC3};
        last = 2'b01;
        push_exp(0, 8'hC3);
        wait_ack(0, 20);
        rst = 1'b1;
        tick();
        req  = '0;
        last = '0;
        @(negedge clk);
        check_reset_vals("midrst");
        tick();
        rst = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
        // Timeout: owner idles, grant clears exactly T cycles later.
        tick();
        do_reset();
        req  = 2'b11;
        data = {8'h66, 8'h44};
        last = 2'b10;
        push_exp(0, 8'h44);
        push_exp(1, 8'h66);
        wait_ack(0, 20);
        tick();
        req[0] = 1'b0;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            check("to_hold_grant", grant, 2'b01);
            tick();
        end
        @(negedge clk);
        check("to_cleared", grant, 0);
        wait_ack(1, 20);
        tick();
        req  = '0;
        last = '0;
`endif

        // Randomized packets, gaps and FIFO draining.
        for (int round = 0; round < 3; round++) begin
            tick();
            do_reset();
            drain_en = 1'b1;
            gen_stim(4, 4);
            build_expected();
            run_stream(3000, 1'b1);
            drain_en = 1'b0;
            @(negedge clk);
            check("rand_err_clear", err, 0);
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-granular round-robin arbiter that shares one buffered UART transmitter between N byte-stream requesters. It drives the transmitter's register port (write-enable, address, write data) and reads its status word back. It writes a byte only when the transmitter FIFO has room, so the downstream FIFO can never overflow. It sits between the transmitter and its clients, for example the CPU-side bridge and the debug monitor.

## Interface
Parameters:
- N, 2, number of requesters (2..8)
- D, 5, log2 depth of the downstream transmitter FIFO (D ≤ 8)
- MARGIN, 2, free FIFO slots always kept in reserve (1 ≤ MARGIN < 2^D)
- T, 255, mid-packet idle timeout in cycles (used only with the timeout macro)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  N  per-requester "byte valid"
- LAST  in  N  per-requester "this byte ends the packet"
- DATA  in  8*N  per-requester byte; requester i uses DATA[8i+7:8i]
- ACK  out  N  one-cycle pulse; the byte of requester i was written
- GRANT  out  N  one-hot owner of the transmitter, or all zero
- BUSY  out  1  GRANT is non-zero
- ERR  out  1  sticky; set if transmitter status bit 30 (overflow) is ever seen as 1
- TX_WE  out  1  transmitter write enable
- TX_A  out  1  transmitter address: 0 = data, 1 = status
- TX_WD  out  32  transmitter write data
- TX_RD  in  32  transmitter read data: bit 31 = not-empty, bit 30 = overflow, bits [7:0] = fill

## Operation
- The block never asserts TX_WE together with TX_A = 1, because that combination resets the transmitter FIFO.
- The state machine has three states: IDLE, CHECK and WRITE. Outputs are decoded from state plus registers.
- **Requester contract:**
  - Hold REQ, DATA and LAST stable until ACK.
  - Drop REQ, or present the next byte, in the cycle after ACK.
- **IDLE**
  - Outputs: TX_A = 1, TX_WE = 0, GRANT = 0.
  - If REQ ≠ 0: pick the first set REQ bit searching upward from pointer PTR, wrapping modulo N.
  - Register that choice as GRANT and go to CHECK.
- **CHECK** (grant owner g)
  - Outputs: TX_A = 1, TX_WE = 0.
  - If REQ[g] = 0: stay in CHECK and keep the grant; the packet is still in progress.
  - Else if TX_RD[7:0] < 2^D − MARGIN: go to WRITE.
  - Compare 9-bit unsigned: TX_RD[7:0] zero-extended against the constant.
  - Else stay in CHECK.
  - Each CHECK cycle, ERR |= TX_RD[30].
- **WRITE**
  - Outputs: TX_A = 0, TX_WE = 1, TX_WD = {24'd0, DATA[g]}, ACK[g] = 1.
  - If LAST[g] = 1: clear GRANT, set PTR = (g+1) mod N, go to IDLE.
  - Otherwise go to CHECK.
- A grant is held from the first byte through the LAST byte. Other requesters wait, even while the owner's REQ is low.
- REQ changes of non-owners have no effect during a packet.
- A single-byte packet has LAST = 1 on its only byte.
- The fill value read in CHECK already reflects the previous WRITE, because the FIFO updates at the edge ending WRITE. Simultaneous draining by the UART only makes the check conservative.

## Timing
- Reset values:
  - State = IDLE, PTR = 0, GRANT = 0, ACK = 0, BUSY = 0, ERR = 0.
  - TX_WE = 0, TX_A = 1, TX_WD = 0.
  - Timeout counter = 0.
- Latency: REQ rises in IDLE at cycle 0 → GRANT at cycle 1 → ACK and TX_WE at cycle 2 (minimum, given FIFO room).
- Throughput: one byte per 2 cycles (CHECK/WRITE alternate).
- FIFO full (fill ≥ 2^D − MARGIN): the block remains in CHECK with no write until fill drops. There is no bound on this wait.
- RESET asserted mid-packet:
  - Next cycle the block is in IDLE with all outputs at reset values.
  - A byte acknowledged on the same edge does not count.
  - The downstream FIFO is not flushed by this block.
- REQ all zero in IDLE: the block stays in IDLE. TX_A = 1 keeps status readable.

## Configuration
- Macro: UART_ARB_TIMEOUT_EN.
- **Defined:**
  - A counter runs while in CHECK with REQ[g] = 0. It clears on any cycle with REQ[g] = 1 and on WRITE.
  - When it reaches T: clear GRANT, set PTR = (g+1) mod N, go to IDLE. The packet is abandoned; no ACK is issued and no byte is written.
- **Undefined:** no counter. An owner that drops REQ mid-packet holds the transmitter indefinitely.

## Test plan
- **Single requester, single byte:**
  - Stimulus: reset, then REQ[0] = 1, DATA = 8'hA5, LAST = 1 at cycle 0.
  - Required: GRANT = 01 at cycle 1; TX_WE = 1, TX_A = 0, TX_WD = 32'h000000A5, ACK[0] = 1 at cycle 2; IDLE at cycle 3.
- **Round robin:**
  - Stimulus: REQ = 11 continuously, each packet 2 bytes.
  - Required: grants alternate 01, 10, 01; no byte interleaving between packets.
- **Backpressure:**
  - Stimulus: D = 5, MARGIN = 2, TX_RD[7:0] = 30.
  - Required: no TX_WE while fill = 30. The write occurs 1 cycle after fill drops to 29.
- **Mid-packet stall:**
  - Stimulus: owner 0 drops REQ for 10 cycles after byte 1 while REQ[1] = 1.
  - Required: GRANT stays 01; byte 2 of requester 0 is written before any byte of requester 1.
- **Timeout (macro defined, T = 8):**
  - Stimulus: owner drops REQ mid-packet.
  - Required: GRANT clears exactly 8 cycles after the first REQ-low CHECK cycle, and the other requester is granted next.
- **ERR / reset:**
  - Stimulus: TX_RD[30] = 1 during CHECK.
  - Required: ERR = 1 until RESET. RESET during WRITE returns all outputs to their reset values on the next cycle.
